// File: rtl/cpu_controller.sv
// Eight-phase instruction sequencer for the 8-bit RISC CPU.
// A 3-bit phase counter plus a sticky halt flag, decoded into datapath strobes.
module cpu_controller #(
  parameter int unsigned PHASE_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         opcode,
  input  logic               zero,
  output logic               sel,
  output logic               rd,
  output logic               ld_ir,
  output logic               halt,
  output logic               inc_pc,
  output logic               ld_ac,
  output logic               ld_pc,
  output logic               wr,
  output logic               data_e,
  output logic [PHASE_W-1:0] phase
);

  localparam logic [2:0] INST_ADDR  = 3'd0;
  localparam logic [2:0] INST_FETCH = 3'd1;
  localparam logic [2:0] INST_LOAD  = 3'd2;
  localparam logic [2:0] IDLE       = 3'd3;
  localparam logic [2:0] OP_ADDR    = 3'd4;
  localparam logic [2:0] OP_FETCH   = 3'd5;
  localparam logic [2:0] ALU_OP     = 3'd6;
  localparam logic [2:0] STORE      = 3'd7;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  logic [2:0] phase_q;
  logic [2:0] phase_d;
  logic       halted_q;
  logic       halted_d;

  logic is_hlt;
  logic is_skz;
  logic is_sto;
  logic is_jmp;
  logic is_aluop;

  // Opcode class decode; only meaningful while phase is 4-7.
  always_comb begin
    is_hlt   = (opcode == OP_HLT);
    is_skz   = (opcode == OP_SKZ);
    is_sto   = (opcode == OP_STO);
    is_jmp   = (opcode == OP_JMP);
    is_aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
               (opcode == OP_XOR) || (opcode == OP_LDA);
  end

  // State register; reset wins over both advance and halt.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  // Next state: advance with wrap, or freeze at OP_ADDR on HLT.
  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if ((phase_q == OP_ADDR) && is_hlt) begin
        halted_d = 1'b1;
      end else begin
        phase_d = phase_q + 3'(1);
      end
    end
  end

  // Strobe decode from phase, opcode class, zero and the halt flag.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    halt   = 1'b0;
    inc_pc = 1'b0;
    ld_ac  = 1'b0;
    ld_pc  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    if (halted_q) begin
      halt = 1'b1;
    end else begin
      case (phase_q)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          halt   = is_hlt;
          inc_pc = !is_hlt;
        end
        OP_FETCH: begin
          rd = is_aluop;
        end
        ALU_OP: begin
          rd     = is_aluop;
          inc_pc = is_skz && zero;
          ld_pc  = is_jmp;
          data_e = is_sto;
        end
        STORE: begin
          rd     = is_aluop;
          ld_ac  = is_aluop;
          ld_pc  = is_jmp;
          wr     = is_sto;
          data_e = is_sto;
        end
        default: begin
          sel = 1'b0;
        end
      endcase
    end
  end

  assign phase = PHASE_W'(phase_q);

endmodule

// File: tb/tb_cpu_controller.sv
// Randomized bench for cpu_controller against a behavioural sequencer model.
module tb_cpu_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e;
  logic [2:0] phase;

  int checks = 0;
  int errors = 0;

  // Reference state: which step of the instruction we are in, and halted.
  int m_step;
  bit m_halted;
  int ld_ac_after_rst;

  cpu_controller #(.PHASE_W(3)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .sel(sel), .rd(rd), .ld_ir(ld_ir), .halt(halt), .inc_pc(inc_pc),
    .ld_ac(ld_ac), .ld_pc(ld_pc), .wr(wr), .data_e(data_e), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step=%0d got=%0h expected=%0h", tag, m_step, got, exp);
    end
  endtask

  // Expected strobes as a set of names, derived from the opcode table.
  function automatic logic [8:0] expected(input int step, input bit halted,
                                          input logic [2:0] op, input logic z);
    bit alu, hlt, skz, sto, jmp;
    logic [8:0] e;  // {sel,rd,ld_ir,halt,inc_pc,ld_ac,ld_pc,wr,data_e}
    alu = (op inside {3'd2, 3'd3, 3'd4, 3'd5});
    hlt = (op == 3'd0);
    skz = (op == 3'd1);
    sto = (op == 3'd6);
    jmp = (op == 3'd7);
    e = '0;
    if (halted) return 9'b0_0010_0000;
    if (step <= 3) e[8] = 1'b1;
    if (step >= 1 && step <= 3) e[7] = 1'b1;
    if (step >= 2 && step <= 3) e[6] = 1'b1;
    if (step == 4) begin
      e[5] = hlt;
      e[4] = !hlt;
    end
    if (step >= 5 && alu) e[7] = 1'b1;
    if (step == 6 && skz && z) e[4] = 1'b1;
    if (step >= 6 && jmp) e[2] = 1'b1;
    if (step >= 6 && sto) e[0] = 1'b1;
    if (step == 7 && sto) e[1] = 1'b1;
    if (step == 7 && alu) e[3] = 1'b1;
    return e;
  endfunction

  // One clock: drive at negedge, compare, then advance the model across posedge.
  task automatic step(input logic r, input logic [2:0] op, input logic z);
    logic [8:0] e;
    string names[9] = '{"sel", "rd", "ld_ir", "halt", "inc_pc", "ld_ac", "ld_pc", "wr", "data_e"};
    logic [8:0] got;
    @(negedge clk);
    rst = r; opcode = op; zero = z;
    #1;
    got = {sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e};
    e = expected(m_step, m_halted, op, z);
    check("phase", 8'(phase), 8'(m_step));
    for (int i = 0; i < 9; i++) check(names[i], 8'(got[8-i]), 8'(e[8-i]));
    if (ld_ac) ld_ac_after_rst++;
    if (r) begin
      m_step = 0;
      m_halted = 1'b0;
    end else if (!m_halted) begin
      if (m_step == 4 && op == 3'd0) m_halted = 1'b1;
      else m_step = (m_step + 1) % 8;
    end
    @(posedge clk);
  endtask

  task automatic run_op(input logic [2:0] op, input int n);
    for (int i = 0; i < n; i++) step(1'b0, op, 1'($urandom));
  endtask

  initial begin
    rst = 1'b1; opcode = 3'd0; zero = 1'b0;
    @(posedge clk);
    m_step = 0; m_halted = 1'b0;

    step(1'b1, 3'($urandom), 1'($urandom));   // held reset: INST_ADDR outputs
    run_op(3'd2, 16);                          // ADD
    run_op(3'd6, 16);                          // STO
    run_op(3'd1, 24);                          // SKZ, zero random
    run_op(3'd7, 16);                          // JMP
    for (int i = 0; i < 8; i++) step(1'b0, 3'd1, 1'b1);  // SKZ with zero held high

    // Walk to OP_ADDR, then HLT and hold with random inputs.
    for (int i = 0; i < 8 && m_step != 4; i++) step(1'b0, 3'($urandom_range(7, 1)), 1'($urandom));
    step(1'b0, 3'd0, 1'($urandom));
    for (int i = 0; i < 24; i++) step(1'b0, 3'($urandom), 1'($urandom));
    step(1'b1, 3'($urandom), 1'($urandom));
    run_op(3'd5, 3);

    // LDA aborted by reset at OP_FETCH: its ld_ac pulse must never appear.
    for (int i = 0; i < 8 && m_step != 5; i++) step(1'b0, 3'd5, 1'($urandom));
    step(1'b1, 3'd5, 1'($urandom));
    ld_ac_after_rst = 0;
    for (int i = 0; i < 7; i++) step(1'b0, 3'd5, 1'($urandom));
    check("lda_rst_no_ld_ac", 8'(ld_ac_after_rst), 8'd0);

    // Fully random traffic with rare resets and HLTs.
    for (int i = 0; i < 3000; i++) begin
      logic r;
      logic [2:0] op;
      r = ($urandom_range(99) < 2);
      op = ($urandom_range(99) < 5) ? 3'd0 : 3'($urandom_range(7, 1));
      step(r, op, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
